// File: rtl/audio_pkg.sv
// audio_pkg: shared audio sample/word types and packing constants.
package audio_pkg;
    typedef logic [7:0]  audio_sample_t;
    typedef logic [31:0] audio_word_t;
    localparam audio_sample_t AUDIO_SILENCE = 8'h80;
    localparam int AUDIO_LANES = 4;
endpackage

// File: rtl/audio_packer.sv
// audio_packer: packs 8-bit samples into 32-bit little-endian words behind a one-deep
// valid/ready output slot, with silence padding of partial words on flush.
module audio_packer
    import audio_pkg::*;
#(
    parameter audio_sample_t PAD_BYTE = AUDIO_SILENCE
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        sample_valid_i,
    input  logic [7:0]  sample_i,
    output logic        sample_ready_o,
    input  logic        flush_i,
    output logic        word_valid_o,
    output logic [31:0] word_data_o,
    input  logic        word_ready_i,
    output logic [1:0]  byte_sel_o,
    output logic [15:0] word_count_o
);
    logic [1:0]  idx_q, idx_d;
    logic [23:0] acc_q, acc_d;
    audio_word_t word_q, word_d;
    logic        wv_q, wv_d, fp_q, fp_d;
    logic [15:0] cnt_q, cnt_d;
    logic        slot_free, accept, eff_flush, full, flush_act, load;
    logic [2:0]  fill;
    audio_word_t cur, pad_word;

    assign slot_free      = !wv_q || word_ready_i;
    assign sample_ready_o = !fp_q && (idx_q != 2'd3 || slot_free);
    assign accept         = sample_valid_i && sample_ready_o;
    assign eff_flush      = flush_i || fp_q;
    assign fill           = {1'b0, idx_q} + {2'b00, accept};
    assign full           = accept && idx_q == 2'd3;
    assign flush_act      = eff_flush && !full && fill != 3'd0;
    // A completed word always has a free slot, since accepting at lane 3 requires it.
    assign load           = full || (flush_act && slot_free);

    // Lanes holding the accepted byte in place; unfilled lanes become padding, so a full word needs none.
    always_comb begin
        cur = {8'h00, acc_q};
        if (accept) cur[idx_q*8 +: 8] = sample_i;
        pad_word = '0;
        for (int k = 0; k < AUDIO_LANES; k++)
            pad_word[k*8 +: 8] = (3'(k) < fill) ? cur[k*8 +: 8] : PAD_BYTE;
    end

    always_comb begin
        idx_d  = load ? 2'd0 : (accept ? idx_q + 2'd1 : idx_q);
        acc_d  = load ? 24'h0 : (accept ? cur[23:0] : acc_q);
        word_d = load ? pad_word : word_q;
        wv_d   = load || (wv_q && !word_ready_i);
        fp_d   = flush_act && !slot_free;
        cnt_d  = (wv_q && word_ready_i) ? cnt_q + 16'd1 : cnt_q;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            idx_q  <= '0;
            acc_q  <= '0;
            word_q <= '0;
            wv_q   <= 1'b0;
            fp_q   <= 1'b0;
            cnt_q  <= '0;
        end else begin
            idx_q  <= idx_d;
            acc_q  <= acc_d;
            word_q <= word_d;
            wv_q   <= wv_d;
            fp_q   <= fp_d;
            cnt_q  <= cnt_d;
        end
    end

    assign word_valid_o = wv_q;
    assign word_data_o  = word_q;
    assign byte_sel_o   = idx_q;
    assign word_count_o = cnt_q;
endmodule

// File: tb/tb_audio_packer.sv
// tb_audio_packer: scoreboard bench; a byte-list model queues expected words, a negedge monitor pops them on transfer.
module tb_audio_packer;
    import audio_pkg::*;
    logic        clk_i = 0, reset_i = 1, sample_valid_i = 0, flush_i = 0, word_ready_i = 0;
    logic [7:0]  sample_i = 0;
    logic        sample_ready_o, word_valid_o;
    logic [31:0] word_data_o;
    logic [1:0]  byte_sel_o;
    logic [15:0] word_count_o;
    int          total = 0, bad = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  part[$];
    logic [15:0] exp_cnt = 0;
    logic [31:0] last_word = 0;

    audio_packer dut (
        .clk_i(clk_i), .reset_i(reset_i), .sample_valid_i(sample_valid_i), .sample_i(sample_i),
        .sample_ready_o(sample_ready_o), .flush_i(flush_i), .word_valid_o(word_valid_o),
        .word_data_o(word_data_o), .word_ready_i(word_ready_i), .byte_sel_o(byte_sel_o),
        .word_count_o(word_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pack_pad();
        logic [31:0] w = {4{8'h80}};
        for (int k = 0; k < part.size(); k++) w[k*8 +: 8] = part[k];
        return w;
    endfunction

    task automatic emit_partial();
        if (part.size() > 0) begin
            exp_q.push_back(pack_pad());
            part.delete();
        end
    endtask

    task automatic accept_model(input logic [7:0] s, input logic f);
        part.push_back(s);
        if (part.size() == 4 || f) emit_partial();
    endtask

    always @(negedge clk_i) begin
        if (!reset_i && word_valid_o && word_ready_i) begin
            if (exp_q.size() == 0) chk("spurious_word", {31'b0, word_valid_o}, 32'd0);
            else begin
                last_word = exp_q.pop_front();
                chk("word", word_data_o, last_word);
            end
            exp_cnt++;
        end
    end

    task automatic send(input logic [7:0] s, input logic f);
        int n = 0;
        sample_valid_i = 1; sample_i = s; flush_i = f;
        @(negedge clk_i);
        while (!sample_ready_o && n < 200) begin
            n++;
            @(negedge clk_i);
        end
        if (!sample_ready_o) chk("ready_timeout", {31'b0, sample_ready_o}, 32'd1);
        else accept_model(s, f);
        @(posedge clk_i); #1;
        sample_valid_i = 0; flush_i = 0;
    endtask

    task automatic flush_pulse();
        flush_i = 1;
        @(negedge clk_i);
        emit_partial();
        @(posedge clk_i); #1;
        flush_i = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        reset_i = 1;
        exp_q.delete(); part.delete(); exp_cnt = 0;
        idle(2);
        reset_i = 0;
    endtask

    initial begin
        idle(2);
        reset_i = 0;
        chk("rst_valid", {31'b0, word_valid_o}, 32'd0);
        chk("rst_ready", {31'b0, sample_ready_o}, 32'd1);
        chk("rst_sel", {30'b0, byte_sel_o}, 32'd0);
        chk("rst_cnt", {16'b0, word_count_o}, 32'd0);
        chk("rst_data", word_data_o, 32'd0);

        word_ready_i = 1;
        foreach (part[i]) part.delete();
        begin
            logic [7:0] v [4] = '{8'h33, 8'h55, 8'h77, 8'h99};
            for (int i = 0; i < 4; i++) begin
                chk("basic_sel", {30'b0, byte_sel_o}, i);
                send(v[i], 0);
            end
        end
        chk("basic_sel_wrap", {30'b0, byte_sel_o}, 32'd0);
        idle(3);
        chk("basic_cnt", {16'b0, word_count_o}, 32'd1);

        word_ready_i = 0;
        begin
            logic [7:0] v [7] = '{8'haa, 8'hbb, 8'hcc, 8'hdd, 8'h12, 8'h34, 8'h56};
            foreach (v[i]) send(v[i], 0);
        end
        idle(2);
        chk("bp_ready", {31'b0, sample_ready_o}, 32'd0);
        chk("bp_sel", {30'b0, byte_sel_o}, 32'd3);
        chk("bp_valid", {31'b0, word_valid_o}, 32'd1);
        chk("bp_hold", word_data_o, 32'hddccbbaa);
        word_ready_i = 1;
        send(8'h78, 0);
        idle(3);
        chk("bp_cnt", {16'b0, word_count_o}, {16'b0, exp_cnt});
        chk("bp_cnt_const", {16'b0, word_count_o}, 32'd3);

        send(8'haa, 0); send(8'hbb, 0); flush_pulse();
        idle(2);
        chk("flush_sel", {30'b0, byte_sel_o}, 32'd0);
        chk("flush_word", last_word, 32'h8080bbaa);

        flush_pulse();
        idle(3);
        chk("flush_idx0_valid", {31'b0, word_valid_o}, 32'd0);
        chk("flush_idx0_cnt", {16'b0, word_count_o}, 32'd4);

        send(8'haa, 0); send(8'hbb, 0); send(8'hcc, 1);
        idle(2);
        chk("flush_coinc_sel", {30'b0, byte_sel_o}, 32'd0);
        chk("flush_coinc_data", word_data_o, 32'h80ccbbaa);

        word_ready_i = 0;
        send(8'ha1, 0); send(8'ha2, 0); send(8'ha3, 0); send(8'ha4, 0);
        send(8'hb1, 0);
        flush_pulse();
        chk("pend_ready", {31'b0, sample_ready_o}, 32'd0);
        idle(2);
        chk("pend_ready2", {31'b0, sample_ready_o}, 32'd0);
        chk("pend_hold", word_data_o, 32'ha4a3a2a1);
        word_ready_i = 1;
        idle(3);
        chk("pend_padded", word_data_o, 32'h808080b1);
        chk("pend_sel", {30'b0, byte_sel_o}, 32'd0);
        chk("pend_ready3", {31'b0, sample_ready_o}, 32'd1);
        chk("pend_drained", exp_q.size(), 32'd0);

        word_ready_i = 0;
        for (int i = 0; i < 6; i++) send(8'hc0 + 8'(i), 0);
        #2 reset_i = 1;
        exp_q.delete(); part.delete(); exp_cnt = 0;
        #1;
        chk("arst_valid", {31'b0, word_valid_o}, 32'd0);
        chk("arst_sel", {30'b0, byte_sel_o}, 32'd0);
        chk("arst_cnt", {16'b0, word_count_o}, 32'd0);
        chk("arst_data", word_data_o, 32'd0);
        chk("arst_ready", {31'b0, sample_ready_o}, 32'd1);
        idle(2);
        reset_i = 0;
        idle(2);
        chk("arst_noword", {31'b0, word_valid_o}, 32'd0);
        word_ready_i = 1;
        send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
        idle(3);
        chk("arst_word", last_word, 32'h04030201);
        chk("arst_cnt2", {16'b0, word_count_o}, 32'd1);

        do_reset();
        word_ready_i = 1;
        for (int i = 0; i < 65536; i++) send(8'(i * 7), 1);
        idle(3);
        chk("wrap_cnt", {16'b0, word_count_o}, 32'd0);
        chk("wrap_model_cnt", {16'b0, word_count_o}, {16'b0, exp_cnt});
        chk("wrap_data", word_data_o, last_word);
        chk("wrap_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/audio_packer.md
# audio_packer

Write-direction counterpart to the audio byte selector. Accepts a stream of 8-bit unsigned audio samples and packs every four of them into a 32-bit little-endian word: the first sample goes in bits [7:0], and a byte_sel of 0 reads it back from there. Finished words go out through a one-deep valid/ready output slot toward the flash/SDRAM writer. A flush pads a partial word with a silence byte.

## Interface
- PAD_BYTE, 8'h80, value written into unfilled lanes on flush (unsigned-audio midpoint, i.e. silence)
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- sample_valid  in  1  sample present on `sample`
- sample  in  8  unsigned audio sample
- sample_ready  out  1  packer can accept a sample this cycle
- flush  in  1  single-cycle request to close the current partial word
- word_valid  out  1  word_data holds a finished word
- word_data  out  32  packed word; lane k = bits [8k+7:8k]
- word_ready  in  1  downstream consumes word this cycle
- byte_sel  out  2  lane index the next accepted sample will occupy
- word_count  out  16  words transferred (word_valid & word_ready); wraps at 16'hFFFF→0

## Operation
- State:
  - `idx` (2b, drives byte_sel)
  - `acc` (24b, lanes 0–2)
  - output slot (`word_data`/`word_valid`)
  - `flush_pending` (1b)
  - `word_count`
- Accept = sample_valid & sample_ready. The sample is written to lane idx and idx increments mod 4.
- slot_free = !word_valid | word_ready.
- sample_ready = !flush_pending & ((idx != 3) | slot_free). This path is combinational from word_ready.
- Word completion on accept at idx 3: the slot loads {sample, acc[23:0]} and word_valid is set. idx becomes 0 and acc clears to 0.
- Flush handling. A flush is "effective" when flush is high, or when flush_pending is set:
  - **Effective flush with idx 0 and no accept:** no-op. flush_pending clears.
  - **Effective flush with a partial word and slot_free:** the slot loads a word made of the filled lanes plus PAD_BYTE in the rest. idx→0, acc→0, flush_pending→0.
  - **Effective flush with no free slot:** flush_pending is set and sample_ready drops. The flush completes on the first cycle slot_free is true.
- flush coincident with an accept:
  - The accepted byte is placed first.
  - If the accept completed the word (idx was 3), the flush is a no-op.
  - Otherwise the remaining lanes are padded and the word is emitted in the same cycle. Emission is possible because the accept already implies slot_free or idx < 3; if the slot is not free, flush_pending is set.
- Output slot:
  - word_data and word_valid stay stable while word_valid & !word_ready.
  - When the slot drains with no new load, word_valid→0 and word_data holds its last value.
  - Load and drain in the same cycle is legal: the new word replaces the old one and word_valid stays 1.
- word_count increments on every word_valid & word_ready.

## Timing
- Reset values: idx 0, acc 0, word_data 32'h0, word_valid 0, flush_pending 0, word_count 0. sample_ready is 1 out of reset.
- Latency:
  - word_valid rises on the clock edge that accepts the 4th byte, so it is visible the cycle after.
  - Flush-padded words follow the same one-edge latency.
- Sustained throughput: one sample per cycle with word_ready held high.
- Reset asserted mid-word discards the partial bytes and any pending word. No word is emitted on release.

## Structure
- Shared package `audio_pkg`:
  - `audio_sample_t` (logic [7:0])
  - `audio_word_t` (logic [31:0])
  - constant AUDIO_SILENCE = 8'h80, the default for PAD_BYTE
  - constant AUDIO_LANES = 4
- No sub-module. The output slot and packer fit in one always_ff plus a small combinational block for ready and padding.

## Test plan
- **Basic packing:** reset, word_ready=1, samples 33,55,77,99 on consecutive cycles → one word 32'h99775533. byte_sel steps 0,1,2,3,0. word_count=1.
- **Backpressure:** word_ready=0, feed 8 samples aa,bb,cc,dd,12,34,56,78.
  - First word 32'hddccbbaa held stable.
  - sample_ready drops with byte_sel=3 after 7 accepts.
  - Raising word_ready → 32'hddccbbaa drains, then 32'h78563412. word_count=2.
- **Flush partial:** samples aa,bb then flush pulse → word 32'h8080bbaa. byte_sel returns to 0.
- **Flush edge cases:**
  - flush at idx 0 → no word.
  - flush coincident with the 3rd sample cc after aa,bb → 32'h80ccbbaa.
  - flush while the slot is full and word_ready=0 → sample_ready=0 until the drain, then the padded word appears.
- **Reset mid-operation:** reset asserted asynchronously after 2 samples and with a pending word → all outputs return to reset values immediately. The next four samples 01,02,03,04 → 32'h04030201.
- **Counter wrap:** 65536 words transferred → word_count returns to 0 without disturbing word_data.
